// File: rtl/alu_arbiter_ctrl.sv
// Round-robin front end that shares one 4-bit ALU between two requesters and returns a registered result.
// Optional build macro CARRY_CHAIN_EN adds a per-requester carry register for chained multi-word arithmetic.
module alu_arbiter_ctrl #(
  parameter int DEFAULT_PRIO  = 0,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_i,
  input  logic       req1_i,
  input  logic [3:0] a0_i,
  input  logic [3:0] a1_i,
  input  logic [3:0] b0_i,
  input  logic [3:0] b1_i,
  input  logic [2:0] s0_i,
  input  logic [2:0] s1_i,
  input  logic       xin0_i,
  input  logic       xin1_i,
  input  logic       usec0_i,
  input  logic       usec1_i,
  output logic       gnt0_o,
  output logic       gnt1_o,
  output logic       rvalid_o,
  input  logic       rready_i,
  output logic       rid_o,
  output logic [3:0] rf_o,
  output logic       rz_o,
  output logic       rv_o,
  output logic       rc_o,
  output logic       busy_o,
  output logic [3:0] alu_a_o,
  output logic [3:0] alu_b_o,
  output logic [2:0] alu_s_o,
  output logic       alu_xin_o,
  input  logic [3:0] alu_f_i,
  input  logic       alu_z_i,
  input  logic       alu_v_i,
  input  logic       alu_c_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    EXEC = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam logic [1:0] LAST_CNT = 2'(SETTLE_CYCLES - 1);
  localparam logic       PRIO_RST = 1'(DEFAULT_PRIO);

  state_t     state_q, state_d;
  logic       ptr_q, ptr_d;
  logic [2:0] sLat_q, sLat_d;
  logic       id_q, id_d;
  logic [1:0] cnt_q, cnt_d;
  logic [3:0] aluA_q, aluA_d;
  logic [3:0] aluB_q, aluB_d;
  logic [2:0] aluS_q, aluS_d;
  logic       aluXin_q, aluXin_d;
  logic [3:0] rf_q, rf_d;
  logic       rz_q, rz_d;
  logic       rv_q, rv_d;
  logic       rc_q, rc_d;
  logic       rid_q, rid_d;

  logic       winValid;
  logic       winId;
  logic [3:0] selA;
  logic [3:0] selB;
  logic [2:0] selS;
  logic       selXin;

  // Winner decode: contention goes to the pointer, a lone request wins outright.
  always_comb begin
    winValid = req0_i | req1_i;
    winId    = (req0_i & req1_i) ? ptr_q : req1_i;
    selA     = winId ? a1_i : a0_i;
    selB     = winId ? b1_i : b0_i;
    selS     = winId ? s1_i : s0_i;
  end

`ifdef CARRY_CHAIN_EN
  logic carry0_q, carry0_d;
  logic carry1_q, carry1_d;

  assign selXin = winId ? (usec1_i ? carry1_q : xin1_i)
                        : (usec0_i ? carry0_q : xin0_i);
`else
  logic unused_usec;

  assign unused_usec = usec0_i ^ usec1_i;
  assign selXin      = winId ? xin1_i : xin0_i;
`endif

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    sLat_d   = sLat_q;
    id_d     = id_q;
    cnt_d    = cnt_q;
    aluA_d   = aluA_q;
    aluB_d   = aluB_q;
    aluS_d   = aluS_q;
    aluXin_d = aluXin_q;
    rf_d     = rf_q;
    rz_d     = rz_q;
    rv_d     = rv_q;
    rc_d     = rc_q;
    rid_d    = rid_q;
    gnt0_o   = 1'b0;
    gnt1_o   = 1'b0;
`ifdef CARRY_CHAIN_EN
    carry0_d = carry0_q;
    carry1_d = carry1_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (winValid) begin
          gnt0_o   = ~winId;
          gnt1_o   = winId;
          aluA_d   = selA;
          aluB_d   = selB;
          aluXin_d = selXin;
          // Inverted op during PREP guarantees ALU_S toggles so the ALU re-evaluates.
          aluS_d   = ~selS;
          sLat_d   = selS;
          id_d     = winId;
          ptr_d    = ~winId;
          state_d  = PREP;
        end
      end
      PREP: begin
        aluS_d  = sLat_q;
        cnt_d   = 2'd0;
        state_d = EXEC;
      end
      EXEC: begin
        if (cnt_q == LAST_CNT) begin
          rf_d    = alu_f_i;
          rz_d    = alu_z_i;
          rv_d    = alu_v_i;
          rc_d    = alu_c_i;
          rid_d   = id_q;
          state_d = RESP;
`ifdef CARRY_CHAIN_EN
          if (id_q) carry1_d = alu_c_i;
          else      carry0_d = alu_c_i;
`endif
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      RESP: begin
        if (rready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset abandons any in-flight op and parks the ALU drive at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ptr_q    <= PRIO_RST;
      sLat_q   <= 3'd0;
      id_q     <= 1'b0;
      cnt_q    <= 2'd0;
      aluA_q   <= 4'd0;
      aluB_q   <= 4'd0;
      aluS_q   <= 3'd0;
      aluXin_q <= 1'b0;
      rf_q     <= 4'd0;
      rz_q     <= 1'b0;
      rv_q     <= 1'b0;
      rc_q     <= 1'b0;
      rid_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      sLat_q   <= sLat_d;
      id_q     <= id_d;
      cnt_q    <= cnt_d;
      aluA_q   <= aluA_d;
      aluB_q   <= aluB_d;
      aluS_q   <= aluS_d;
      aluXin_q <= aluXin_d;
      rf_q     <= rf_d;
      rz_q     <= rz_d;
      rv_q     <= rv_d;
      rc_q     <= rc_d;
      rid_q    <= rid_d;
    end
  end

`ifdef CARRY_CHAIN_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry0_q <= 1'b0;
      carry1_q <= 1'b0;
    end else begin
      carry0_q <= carry0_d;
      carry1_q <= carry1_d;
    end
  end
`endif

  assign rvalid_o  = (state_q == RESP);
  assign busy_o    = (state_q != IDLE);
  assign rid_o     = rid_q;
  assign rf_o      = rf_q;
  assign rz_o      = rz_q;
  assign rv_o      = rv_q;
  assign rc_o      = rc_q;
  assign alu_a_o   = aluA_q;
  assign alu_b_o   = aluB_q;
  assign alu_s_o   = aluS_q;
  assign alu_xin_o = aluXin_q;

endmodule

// File: tb/tb_alu_arbiter_ctrl.sv
// Directed bench for alu_arbiter_ctrl: a behavioural ALU closes the loop, a scoreboard predicts each result.
// Honours CARRY_CHAIN_EN the same way the design does.
module tb_alu_arbiter_ctrl;

  localparam int SETTLE = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0_i = 1'b0, req1_i = 1'b0;
  logic [3:0] a0_i = '0, a1_i = '0, b0_i = '0, b1_i = '0;
  logic [2:0] s0_i = '0, s1_i = '0;
  logic       xin0_i = 1'b0, xin1_i = 1'b0, usec0_i = 1'b0, usec1_i = 1'b0;
  logic       rready_i = 1'b1;
  logic       gnt0_o, gnt1_o, rvalid_o, rid_o, rz_o, rv_o, rc_o, busy_o, alu_xin_o;
  logic [3:0] rf_o, alu_a_o, alu_b_o;
  logic [2:0] alu_s_o;
  logic [3:0] alu_f_i;
  logic       alu_z_i, alu_v_i, alu_c_i;

  typedef struct {
    logic       id;
    logic [3:0] f;
    logic       z;
    logic       v;
    logic       c;
    int         cyc;
  } exp_t;

  exp_t expQ[$];
  int   grantIds[$];
  int   grantCycles[$];
  logic crModel[2] = '{1'b0, 1'b0};
  logic rvalidSeen = 1'b0;
  int   passCount = 0;
  int   checkCount = 0;
  int   cycle = 0;

  always #5 clk = ~clk;

  alu_arbiter_ctrl #(.DEFAULT_PRIO(0), .SETTLE_CYCLES(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_i(req0_i), .req1_i(req1_i),
    .a0_i(a0_i), .a1_i(a1_i), .b0_i(b0_i), .b1_i(b1_i),
    .s0_i(s0_i), .s1_i(s1_i), .xin0_i(xin0_i), .xin1_i(xin1_i),
    .usec0_i(usec0_i), .usec1_i(usec1_i),
    .gnt0_o(gnt0_o), .gnt1_o(gnt1_o),
    .rvalid_o(rvalid_o), .rready_i(rready_i), .rid_o(rid_o),
    .rf_o(rf_o), .rz_o(rz_o), .rv_o(rv_o), .rc_o(rc_o), .busy_o(busy_o),
    .alu_a_o(alu_a_o), .alu_b_o(alu_b_o), .alu_s_o(alu_s_o), .alu_xin_o(alu_xin_o),
    .alu_f_i(alu_f_i), .alu_z_i(alu_z_i), .alu_v_i(alu_v_i), .alu_c_i(alu_c_i)
  );

  // Toy ALU: add/sub report carry on both C and V, Z flags A==B like a 74181 comparator.
  function automatic logic [6:0] aluModel(input logic [3:0] a, input logic [3:0] b,
                                          input logic [2:0] s, input logic xin);
    logic [4:0] wide;
    logic [3:0] f;
    logic       c;
    wide = 5'd0;
    c    = 1'b0;
    case (s)
      3'b000: begin wide = {1'b0, a} + {1'b0, b} + {4'd0, xin}; f = wide[3:0]; c = wide[4]; end
      3'b001: begin wide = {1'b0, a} - {1'b0, b} - {4'd0, xin}; f = wide[3:0]; c = wide[4]; end
      3'b010: f = a & b;
      3'b011: f = a | b;
      3'b100: f = a ^ b;
      3'b101: f = ~a;
      3'b110: f = a;
      default: f = b;
    endcase
    return {f, (a == b), c, c};
  endfunction

  always_comb {alu_f_i, alu_z_i, alu_v_i, alu_c_i} = aluModel(alu_a_o, alu_b_o, alu_s_o, alu_xin_o);

  always @(posedge clk) cycle++;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
  endtask

  // Grant monitor: predicts the result from the winner's inputs on the grant cycle.
  always @(negedge clk) begin
    if (rst_n && (gnt0_o || gnt1_o)) begin
      exp_t       e;
      logic       id;
      logic       xinEff;
      logic [6:0] r;
      checkOutput("gnt_onehot", 32'(gnt0_o & gnt1_o), 0);
      id     = gnt1_o;
      xinEff = id ? xin1_i : xin0_i;
`ifdef CARRY_CHAIN_EN
      if (id ? usec1_i : usec0_i) xinEff = crModel[id];
`endif
      r = id ? aluModel(a1_i, b1_i, s1_i, xinEff) : aluModel(a0_i, b0_i, s0_i, xinEff);
      e.id = id; e.f = r[6:3]; e.z = r[2]; e.v = r[1]; e.c = r[0]; e.cyc = cycle;
`ifdef CARRY_CHAIN_EN
      crModel[id] = r[0];
`endif
      expQ.push_back(e);
      grantIds.push_back(int'(id));
      grantCycles.push_back(cycle);
    end
  end

  // Response monitor: every RVALID cycle must match the oldest outstanding prediction.
  always @(negedge clk) begin
    if (!rst_n) begin
      rvalidSeen = 1'b0;
    end else if (rvalid_o) begin
      if (expQ.size() == 0) begin
        checkOutput("rvalid_without_op", 32'(rvalid_o), 0);
      end else begin
        checkOutput("sb_rid", 32'(rid_o), 32'(expQ[0].id));
        checkOutput("sb_rf", 32'(rf_o), 32'(expQ[0].f));
        checkOutput("sb_flags", 32'({rz_o, rv_o, rc_o}), 32'({expQ[0].z, expQ[0].v, expQ[0].c}));
        if (!rvalidSeen) checkOutput("sb_latency", cycle - expQ[0].cyc, 2 + SETTLE);
        rvalidSeen = 1'b1;
        if (rready_i) begin
          void'(expQ.pop_front());
          rvalidSeen = 1'b0;
        end
      end
    end
  end

  task automatic applyStimulus(input int id, input logic [3:0] a, input logic [3:0] b,
                               input logic [2:0] s, input logic xin, input logic usec);
    if (id == 0) begin
      a0_i = a; b0_i = b; s0_i = s; xin0_i = xin; usec0_i = usec; req0_i = 1'b1;
    end else begin
      a1_i = a; b1_i = b; s1_i = s; xin1_i = xin; usec1_i = usec; req1_i = 1'b1;
    end
  endtask

  task automatic dropReq(input int id);
    @(posedge clk);
    #1;
    if (id == 0) req0_i = 1'b0;
    else         req1_i = 1'b0;
  endtask

  task automatic waitGrant(input int id);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = (id == 0) ? gnt0_o : gnt1_o;
    end
    if (!seen) checkOutput($sformatf("gnt%0d_timeout", id), 32'(seen), 1);
  endtask

  task automatic waitRvalid();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = rvalid_o;
    end
    if (!seen) checkOutput("rvalid_timeout", 32'(seen), 1);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_gnt"}, 32'({gnt0_o, gnt1_o}), 0);
    checkOutput({tag, "_rvalid"}, 32'(rvalid_o), 0);
    checkOutput({tag, "_rid"}, 32'(rid_o), 0);
    checkOutput({tag, "_rf"}, 32'(rf_o), 0);
    checkOutput({tag, "_flags"}, 32'({rz_o, rv_o, rc_o}), 0);
    checkOutput({tag, "_busy"}, 32'(busy_o), 0);
    checkOutput({tag, "_alu_ab"}, 32'({alu_a_o, alu_b_o}), 0);
    checkOutput({tag, "_alu_s"}, 32'(alu_s_o), 0);
    checkOutput({tag, "_alu_xin"}, 32'(alu_xin_o), 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    #12;
    checkResetOutputs("por");
    @(posedge clk); #1 rst_n = 1'b1;

    // Overflowing add: flags are whatever the ALU reported at capture.
    @(posedge clk); #1 applyStimulus(0, 4'hF, 4'h1, 3'b000, 1'b0, 1'b0);
    waitGrant(0);
    dropReq(0);
    waitRvalid();
    checkOutput("ovf_rf", 32'(rf_o), 0);
    checkOutput("ovf_flags", 32'({rz_o, rv_o, rc_o}), 32'(3'b011));

    // Cycle-exact walk through one op: 3 + 5.
    @(posedge clk); #1 applyStimulus(0, 4'd3, 4'd5, 3'b000, 1'b0, 1'b0);
    waitGrant(0);
    dropReq(0);
    @(negedge clk);
    checkOutput("prep_alu_s", 32'(alu_s_o), 7);
    checkOutput("prep_alu_ab", 32'({alu_a_o, alu_b_o}), 32'(8'h35));
    checkOutput("prep_busy", 32'(busy_o), 1);
    checkOutput("prep_no_gnt", 32'({gnt0_o, gnt1_o}), 0);
    @(negedge clk);
    checkOutput("exec_alu_s", 32'(alu_s_o), 0);
    checkOutput("exec_rvalid", 32'(rvalid_o), 0);
    @(negedge clk);
    checkOutput("resp_rvalid", 32'(rvalid_o), 1);
    checkOutput("resp_rf", 32'(rf_o), 8);
    checkOutput("resp_flags", 32'({rz_o, rv_o, rc_o}), 0);
    checkOutput("resp_rid", 32'(rid_o), 0);
    @(negedge clk);
    checkOutput("after_rvalid", 32'(rvalid_o), 0);
    checkOutput("after_busy", 32'(busy_o), 0);

    // Asynchronous reset while an op sits in EXEC.
    @(posedge clk); #1 applyStimulus(0, 4'd6, 4'd2, 3'b001, 1'b0, 1'b0);
    waitGrant(0);
    dropReq(0);
    @(negedge clk);
    @(negedge clk);
    checkOutput("pre_rst_busy", 32'(busy_o), 1);
    #2 rst_n = 1'b0;
    #1 checkResetOutputs("async_rst");
    expQ.delete();
    crModel = '{1'b0, 1'b0};
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkOutput("post_rst_rvalid", 32'(rvalid_o), 0);
    end

    // Both requesters held: strict alternation starting from requester 0.
    grantIds.delete();
    grantCycles.delete();
    @(posedge clk); #1;
    applyStimulus(0, 4'd1, 4'd2, 3'b000, 1'b0, 1'b0);
    applyStimulus(1, 4'd4, 4'd4, 3'b100, 1'b1, 1'b0);
    for (int i = 0; i < 40 && grantIds.size() < 4; i++) @(negedge clk);
    @(posedge clk); #1;
    req0_i = 1'b0;
    req1_i = 1'b0;
    checkOutput("rr_grant_count", grantIds.size(), 4);
    for (int i = 0; i < grantIds.size() && i < 4; i++)
      checkOutput($sformatf("rr_grant_%0d", i), grantIds[i], i % 2);
    for (int i = 1; i < grantCycles.size() && i < 4; i++)
      checkOutput($sformatf("rr_period_%0d", i), grantCycles[i] - grantCycles[i-1], 3 + SETTLE);
    repeat (8) @(negedge clk);

    // Back-pressure: result must hold and the pending requester must wait.
    @(posedge clk); #1 rready_i = 1'b0;
    applyStimulus(0, 4'h9, 4'h3, 3'b011, 1'b0, 1'b0);
    waitGrant(0);
    dropReq(0);
    applyStimulus(1, 4'h5, 4'hA, 3'b011, 1'b0, 1'b0);
    waitRvalid();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("stall_rvalid", 32'(rvalid_o), 1);
      checkOutput("stall_busy", 32'(busy_o), 1);
      checkOutput("stall_no_gnt", 32'(gnt1_o), 0);
      checkOutput("stall_rf", 32'(rf_o), 32'(4'hB));
    end
    @(posedge clk); #1 rready_i = 1'b1;
    @(negedge clk);
    checkOutput("release_no_gnt_yet", 32'(gnt1_o), 0);
    @(negedge clk);
    checkOutput("release_gnt1", 32'(gnt1_o), 1);
    checkOutput("release_rvalid_low", 32'(rvalid_o), 0);
    dropReq(1);
    waitRvalid();
    @(negedge clk);

    // Carry chaining: USEC selects the stored carry only when the feature is built in.
    @(posedge clk); #1 applyStimulus(0, 4'hF, 4'h1, 3'b000, 1'b0, 1'b0);
    waitGrant(0);
    dropReq(0);
    waitRvalid();
    @(posedge clk); #1 applyStimulus(0, 4'h0, 4'h0, 3'b000, 1'b0, 1'b1);
    waitGrant(0);
    dropReq(0);
    usec0_i = 1'b0;
    @(negedge clk);
`ifdef CARRY_CHAIN_EN
    checkOutput("chain0_xin", 32'(alu_xin_o), 1);
`else
    checkOutput("chain0_xin", 32'(alu_xin_o), 0);
`endif
    waitRvalid();
`ifdef CARRY_CHAIN_EN
    checkOutput("chain0_rf", 32'(rf_o), 1);
`else
    checkOutput("chain0_rf", 32'(rf_o), 0);
`endif
    @(posedge clk); #1 applyStimulus(1, 4'h0, 4'h0, 3'b000, 1'b1, 1'b1);
    waitGrant(1);
    dropReq(1);
    usec1_i = 1'b0;
    @(negedge clk);
`ifdef CARRY_CHAIN_EN
    checkOutput("chain1_xin", 32'(alu_xin_o), 0);
`else
    checkOutput("chain1_xin", 32'(alu_xin_o), 1);
`endif
    waitRvalid();
    repeat (3) @(negedge clk);
    checkOutput("sb_drained", expQ.size(), 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
